hex_msg_scheduler: RTL and testbench

//  Sequences character codes onto the board's bank of char_7seg decoders (HEX5..HEX0).

---
 rtl/hex_msg_scheduler.sv | 168 ++++++++++++++++
 tb/tb_hex_msg_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_msg_scheduler.sv
// rtl/hex_msg_scheduler.sv - message buffer and display sequencer for the HEX5..HEX0 char_7seg bank
//
// Game logic streams 4-bit glyph codes into a buffer; the block then shows the
// message static, scrolling or blinking on NUM_DIGITS seven-segment digits.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous reset, active low
//   wr_valid    message char valid
//   wr_ready    block can accept a char this cycle
//   wr_char     char code (char_7seg input encoding)
//   wr_last     final char of message (sampled on accepted beat)
//   mode        00 static, 01 scroll, 10 blink, 11 static
//   clear       synchronous abort/blank, returns to IDLE
//   digit_char  char code per digit, digit k at [4k+3:4k]
//   digit_on    1 = digit lit, 0 = digit blanked by top level
//   busy        1 while a message is being loaded
module hex_msg_scheduler #(
   parameter int NUM_DIGITS = 6,
   parameter int BUF_DEPTH  = 16,
   parameter int TICK_DIV   = 12_500_000
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [3:0]              wr_char,
   input  logic                    wr_last,
   input  logic [1:0]              mode,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] digit_char,
   output logic [NUM_DIGITS-1:0]   digit_on,
   output logic                    busy
);

   localparam int AW = $clog2(BUF_DEPTH);
   // One extra bit so pointers, lengths and offset+digit positions never wrap.
   localparam int PW = AW + 1;
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW} state_t;

   state_t          state;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   len;
   logic [PW-1:0]   offset;
   logic [TW-1:0]   prescaler;
   logic            blink_phase;
   logic [1:0]      mode_q;
   logic [3:0]      mem [BUF_DEPTH];

   logic            accept;
   logic [PW-1:0]   wr_idx;
   logic            commit;
   logic            tick;
   logic            scroll_en;
   logic            blink_en;
   logic            mode_chg;
   logic [PW-1:0]   p;
   logic [4*NUM_DIGITS-1:0] img_char;
   logic [NUM_DIGITS-1:0]   img_on;

   assign accept    = wr_valid & wr_ready;
   // A fresh message always starts at buf[0]; only LOAD continues at wr_ptr.
   assign wr_idx    = (state == S_LOAD) ? wr_ptr : '0;
   assign commit    = accept & (wr_last | (wr_idx == PW'(BUF_DEPTH - 1)));
   assign tick      = (state == S_SHOW) && (prescaler == TW'(TICK_DIV - 1));
   assign scroll_en = (mode == 2'b01) && (len > PW'(NUM_DIGITS));
   assign blink_en  = (mode == 2'b10);
   assign mode_chg  = (mode != mode_q);

   // Display image from the current registered state; registered below, so
   // the picture lags the state by one clock.
   always_comb begin
      img_char = '0;
      img_on   = '0;
      p        = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         p = offset + PW'(NUM_DIGITS - 1 - k);
         if (p < len) begin
            img_char[4*k +: 4] = mem[p[AW-1:0]];
            img_on[k]          = blink_phase;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !clear) begin
         mem[wr_idx[AW-1:0]] <= wr_char;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         len         <= '0;
         offset      <= '0;
         prescaler   <= '0;
         blink_phase <= 1'b1;
         mode_q      <= 2'b00;
         wr_ready    <= 1'b0;
         busy        <= 1'b0;
         digit_char  <= '0;
         digit_on    <= '0;
      end else begin
         mode_q   <= mode;
         // LOAD always commits on the BUF_DEPTH-th char, so the buffer is
         // never full while loading and a char can be taken every cycle.
         wr_ready <= 1'b1;
         if (state == S_SHOW) begin
            digit_char <= img_char;
            digit_on   <= img_on;
         end else begin
            digit_char <= '0;
            digit_on   <= '0;
         end

         if (clear) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            offset      <= '0;
            prescaler   <= '0;
            blink_phase <= 1'b1;
            busy        <= 1'b0;
            digit_char  <= '0;
            digit_on    <= '0;
         end else if (accept) begin
            wr_ptr <= wr_idx + PW'(1);
            if (commit) begin
               state       <= S_SHOW;
               len         <= wr_idx + PW'(1);
               offset      <= '0;
               prescaler   <= '0;
               blink_phase <= 1'b1;
               busy        <= 1'b0;
            end else begin
               state <= S_LOAD;
               busy  <= 1'b1;
            end
         end else if (state == S_SHOW) begin
            if (mode_chg) begin
               offset      <= '0;
               blink_phase <= 1'b1;
               prescaler   <= '0;
            end else begin
               prescaler <= tick ? '0 : prescaler + TW'(1);
               if (scroll_en) begin
                  blink_phase <= 1'b1;
                  if (tick) begin
                     // Wrap only after the last char has scrolled off the left.
                     offset <= (offset == len - PW'(1)) ? '0 : offset + PW'(1);
                  end
               end else if (blink_en) begin
                  offset <= '0;
                  if (tick) begin
                     blink_phase <= ~blink_phase;
                  end
               end else begin
                  offset      <= '0;
                  blink_phase <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_msg_scheduler.sv
// tb/tb_hex_msg_scheduler.sv - self-checking bench for hex_msg_scheduler
module tb_hex_msg_scheduler;

   localparam int ND  = 6;
   localparam int BD  = 16;
   localparam int TD  = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          wr_valid;
   logic          wr_ready;
   logic [3:0]    wr_char;
   logic          wr_last;
   logic [1:0]    mode;
   logic          clear;
   logic [23:0]   digit_char;
   logic [5:0]    digit_on;
   logic          busy;

   hex_msg_scheduler #(.NUM_DIGITS(ND), .BUF_DEPTH(BD), .TICK_DIV(TD)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_char    (wr_char),
      .wr_last    (wr_last),
      .mode       (mode),
      .clear      (clear),
      .digit_char (digit_char),
      .digit_on   (digit_on),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: message as a queue, display derived from the number of
   // SHOW edges elapsed since the last commit or mode change.
   int          m_st;      // 0 idle, 1 load, 2 show
   int          m_len;
   int          m_e;
   logic [1:0]  m_pmode;
   bit          m_ready;
   int          msg[$];
   int          cur[$];
   logic [23:0] e_char;
   logic [5:0]  e_on;
   bit          e_busy;
   bit          e_ready;

   typedef struct {
      bit          v;
      logic [3:0]  c;
      bit          l;
      logic [1:0]  m;
      bit          clr;
      logic [5:0]  on;
      logic [23:0] ch;
      bit          bsy;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_len = 0; m_e = 0; m_pmode = 2'b00; m_ready = 0;
      msg.delete(); cur.delete();
      e_char = '0; e_on = '0; e_busy = 0; e_ready = 0;
   endtask

   task automatic model_edge();
      logic [23:0] ch;
      logic [5:0]  on;
      int          off;
      int          p;
      bit          ph;
      ch = '0; on = '0;
      if (m_st == 2) begin
         off = (m_pmode == 2'b01 && m_len > ND) ? (m_e / TD) % m_len : 0;
         ph  = (m_pmode == 2'b10) ? ((m_e / TD) % 2 == 0) : 1'b1;
         for (int k = 0; k < ND; k++) begin
            p = off + ND - 1 - k;
            if (p < m_len) begin
               ch[4*k +: 4] = 4'(msg[p]);
               on[k]        = ph;
            end
         end
      end
      if (clear) begin
         ch = '0; on = '0; m_st = 0;
      end else if (wr_valid && m_ready) begin
         if (m_st != 1) cur.delete();
         cur.push_back(int'(wr_char));
         if (wr_last || cur.size() == BD) begin
            msg = cur; m_len = cur.size(); m_st = 2; m_e = 0;
         end else begin
            m_st = 1;
         end
      end else if (m_st == 2) begin
         if (mode != m_pmode) m_e = 0;
         else m_e++;
      end
      m_pmode = mode;
      m_ready = 1;
      e_char = ch; e_on = on; e_busy = (m_st == 1); e_ready = 1;
   endtask

   task automatic cyc(input bit v, input logic [3:0] c, input bit l, input logic [1:0] m, input bit clr);
      wr_valid = v; wr_char = c; wr_last = l; mode = m; clear = clr;
      model_edge();
      @(posedge clk); #1;
      chk("model_digit_char", 32'(digit_char), 32'(e_char));
      chk("model_digit_on",   32'(digit_on),   32'(e_on));
      chk("model_busy",       32'(busy),       32'(e_busy));
      chk("model_wr_ready",   32'(wr_ready),   32'(e_ready));
   endtask

   initial begin
      vec_t tbl[10];
      tbl[0] = '{1'b1, 4'h3, 1'b0, 2'b00, 1'b0, 6'b000000, 24'h000000, 1'b1};
      tbl[1] = '{1'b1, 4'h1, 1'b0, 2'b00, 1'b0, 6'b000000, 24'h000000, 1'b1};
      tbl[2] = '{1'b1, 4'h4, 1'b1, 2'b00, 1'b0, 6'b000000, 24'h000000, 1'b0};
      tbl[3] = '{1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 6'b111000, 24'h314000, 1'b0};
      tbl[4] = '{1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 6'b111000, 24'h314000, 1'b0};
      tbl[5] = '{1'b1, 4'h9, 1'b0, 2'b00, 1'b1, 6'b000000, 24'h000000, 1'b0};
      tbl[6] = '{1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 6'b000000, 24'h000000, 1'b0};
      tbl[7] = '{1'b1, 4'h5, 1'b0, 2'b00, 1'b0, 6'b000000, 24'h000000, 1'b1};
      tbl[8] = '{1'b1, 4'h6, 1'b1, 2'b00, 1'b0, 6'b000000, 24'h000000, 1'b0};
      tbl[9] = '{1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 6'b110000, 24'h560000, 1'b0};

      resetn = 1'b0; wr_valid = 0; wr_char = 0; wr_last = 0; mode = 0; clear = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_digit_on",   32'(digit_on),   32'h0);
      chk("reset_digit_char", 32'(digit_char), 32'h0);
      chk("reset_busy",       32'(busy),       32'h0);
      chk("reset_wr_ready",   32'(wr_ready),   32'h0);
      resetn = 1'b1;
      cyc(0, 0, 0, 2'b00, 0);
      chk("ready_after_reset", 32'(wr_ready), 32'h1);

      // Static message, clear racing a write, then a short message.
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].m, tbl[i].clr);
         chk($sformatf("tbl%0d_on", i),   32'(digit_on),   32'(tbl[i].on));
         chk($sformatf("tbl%0d_char", i), 32'(digit_char), 32'(tbl[i].ch));
         chk($sformatf("tbl%0d_busy", i), 32'(busy),       32'(tbl[i].bsy));
      end

      // Scroll: 8 chars 0..7.
      for (int i = 0; i < 8; i++) cyc(1, 4'(i), i == 7, 2'b01, 0);
      for (int j = 1; j <= 33; j++) begin
         cyc(0, 0, 0, 2'b01, 0);
         if (j == 1)  begin chk("scroll_off0_char", 32'(digit_char), 32'h012345); chk("scroll_off0_on", 32'(digit_on), 32'h3f); end
         if (j == 5)  begin chk("scroll_off1_char", 32'(digit_char), 32'h123456); chk("scroll_off1_on", 32'(digit_on), 32'h3f); end
         if (j == 13) begin chk("scroll_off3_char", 32'(digit_char), 32'h345670); chk("scroll_off3_on", 32'(digit_on), 32'h3e); end
         if (j == 29) begin chk("scroll_off7_char", 32'(digit_char), 32'h700000); chk("scroll_off7_on", 32'(digit_on), 32'h20); end
         if (j == 33) begin chk("scroll_wrap_char", 32'(digit_char), 32'h012345); chk("scroll_wrap_on", 32'(digit_on), 32'h3f); end
      end

      // Blink: A,B.
      cyc(1, 4'hA, 0, 2'b10, 0);
      cyc(1, 4'hB, 1, 2'b10, 0);
      for (int j = 1; j <= 9; j++) begin
         cyc(0, 0, 0, 2'b10, 0);
         if (j == 1) chk("blink_on_a",  32'(digit_on), 32'h30);
         if (j == 5) chk("blink_off",   32'(digit_on), 32'h00);
         if (j == 5) chk("blink_char",  32'(digit_char), 32'hab0000);
         if (j == 9) chk("blink_on_b",  32'(digit_on), 32'h30);
      end

      // Overflow: 16 chars without wr_last.
      for (int i = 0; i < 16; i++) cyc(1, 4'(i), 0, 2'b00, 0);
      chk("ovf_busy",  32'(busy),     32'h0);
      chk("ovf_ready", 32'(wr_ready), 32'h1);
      cyc(0, 0, 0, 2'b00, 0);
      chk("ovf_static_char", 32'(digit_char), 32'h012345);
      for (int n = 1; n <= 42; n++) cyc(0, 0, 0, 2'b01, 0);
      chk("ovf_scroll_char", 32'(digit_char), 32'habcdef);
      chk("ovf_scroll_on",   32'(digit_on),   32'h3f);

      // Asynchronous reset while showing.
      resetn = 1'b0;
      #2;
      chk("async_rst_on",   32'(digit_on),   32'h0);
      chk("async_rst_char", 32'(digit_char), 32'h0);
      chk("async_rst_busy", 32'(busy),       32'h0);
      model_reset();
      @(posedge clk); #1;
      resetn = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bit          v;
         bit          l;
         bit          clr;
         logic [1:0]  m;
         m   = ($urandom_range(0, 40) == 0) ? 2'($urandom) : mode;
         v   = (m_st == 1) ? ($urandom_range(0, 9) < 8) :
               (m_st == 2) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0);
         l   = (m_st == 1) && ($urandom_range(0, 5) == 0);
         clr = ($urandom_range(0, 99) == 0);
         cyc(v, 4'($urandom), l, m, clr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
